// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a five-stage core.
// Generates stall/flush controls, operand forwarding selects, a memory-wait
// watchdog with sticky timeout flag, and stall/flush performance counters.
// Build option: define HAZARD_FORWARD_EN to enable M/W-stage forwarding with a
// single-bubble load-use stall; without it, any RAW dependency on E or M stalls.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | pipeline advancing normally, watchdog held at zero
// MEM_WAIT | data memory busy, pipeline frozen, watchdog counting
module hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int TIMEOUT_W      = 8,
   parameter int CNT_W          = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
   input  logic [REG_ADDR_WIDTH-1:0] RdE,
   input  logic                      LoadE,
   input  logic                      RegWriteE,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   input  logic                      RegWriteM,
   input  logic [REG_ADDR_WIDTH-1:0] RdW,
   input  logic                      RegWriteW,
   input  logic                      PCSrcE,
   input  logic                      MemBusy,
   output logic                      StallF,
   output logic                      StallD,
   output logic                      StallE,
   output logic                      StallM,
   output logic                      FlushD,
   output logic                      FlushE,
   output logic                      FlushW,
   output logic [1:0]                ForwardAE,
   output logic [1:0]                ForwardBE,
   output logic                      MemTimeout,
   output logic [CNT_W-1:0]          StallCount,
   output logic [CNT_W-1:0]          FlushCount
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

   state_t               state, state_nxt;
   logic [TIMEOUT_W-1:0] wd_cnt, wd_nxt;
   logic                 dec_hazard;
   logic                 unused_inputs;

   // State register; reset abandons any memory wait in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next state: enter/stay in MEM_WAIT while memory is busy.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (MemBusy)  state_nxt = MEM_WAIT;
         MEM_WAIT: if (!MemBusy) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   // Watchdog next value: counts wait cycles, saturates, clears when back in RUN.
   always_comb begin
      wd_nxt = '0;
      if (state_nxt == MEM_WAIT) begin
         if (wd_cnt == WD_MAX) wd_nxt = WD_MAX;
         else                  wd_nxt = wd_cnt + TIMEOUT_W'(1);
      end
   end

   // Watchdog counter and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt     <= '0;
         MemTimeout <= 1'b0;
      end else begin
         wd_cnt <= wd_nxt;
         if (wd_nxt == WD_MAX) MemTimeout <= 1'b1;
      end
   end

`ifdef HAZARD_FORWARD_EN
   // Only a load in Execute cannot be forwarded in time for Decode.
   assign dec_hazard = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // Forward selects: M-stage result beats W-stage result, x0 never forwards.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst) begin
         if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
         else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
         if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
         else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
      end
   end

   assign unused_inputs = RegWriteE;
`else
   // Without forwarding, a Decode source must wait for any pending E or M write.
   // W is not checked: the register file writes before it is read.
   assign dec_hazard =
      ((Rs1D != '0) && ((RegWriteE && (RdE == Rs1D)) || (RegWriteM && (RdM == Rs1D)))) ||
      ((Rs2D != '0) && ((RegWriteE && (RdE == Rs2D)) || (RegWriteM && (RdM == Rs2D))));

   assign ForwardAE = 2'b00;
   assign ForwardBE = 2'b00;

   assign unused_inputs = ^{LoadE, Rs1E, Rs2E, RdW, RegWriteW};
`endif

   // Stall/flush decode, priority: reset, memory busy, taken branch, data hazard.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (rst) begin
         StallF = 1'b0;
      end else if (MemBusy) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (dec_hazard) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   // Performance counters, wrapping naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallF) StallCount <= StallCount + CNT_W'(1);
         if (FlushD) FlushCount <= FlushCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios followed by randomized traffic, all
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

   localparam int AW  = 5;
   localparam int TW  = 4;
   localparam int CW  = 6;
   localparam int CNT_MOD = 1 << CW;
   localparam int WD_LIMIT = (1 << TW) - 1;
`ifdef HAZARD_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   localparam logic [6:0] C_IDLE = 7'b0000000;
   localparam logic [6:0] C_BUSY = 7'b1111001;
   localparam logic [6:0] C_BR   = 7'b0000110;
   localparam logic [6:0] C_HAZ  = 7'b1100010;

   logic clk = 1'b0;
   logic rst;
   logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic LoadE, RegWriteE, RegWriteM, RegWriteW, PCSrcE, MemBusy;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic MemTimeout;
   logic [CW-1:0] StallCount, FlushCount;
   logic [6:0] obs_ctrl;

   int checks = 0;
   int errors = 0;

   int m_stall_cnt, m_flush_cnt, m_busy_run;
   bit m_timeout;

   always #5 clk = ~clk;

   assign obs_ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   hazard_ctrl #(.REG_ADDR_WIDTH(AW), .TIMEOUT_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .LoadE(LoadE), .RegWriteE(RegWriteE), .RdM(RdM), .RegWriteM(RegWriteM),
      .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemBusy(MemBusy),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   function automatic bit reads_pending(logic [AW-1:0] r);
      return (r != 0) && ((RegWriteE && RdE == r) || (RegWriteM && RdM == r));
   endfunction

   // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} for the current inputs.
   function automatic logic [6:0] exp_ctrl();
      bit hz;
      if (rst)     return C_IDLE;
      if (MemBusy) return C_BUSY;
      if (PCSrcE)  return C_BR;
      if (FWD_EN) hz = LoadE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
      else        hz = reads_pending(Rs1D) || reads_pending(Rs2D);
      return hz ? C_HAZ : C_IDLE;
   endfunction

   function automatic logic [1:0] exp_fwd(logic [AW-1:0] src);
      if (rst || src == 0 || !FWD_EN) return 2'b00;
      if (RegWriteM && RdM == src) return 2'b10;
      if (RegWriteW && RdW == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      m_busy_run  = 0;
      m_timeout   = 1'b0;
   endtask

   task automatic model_update();
      logic [6:0] c;
      c = exp_ctrl();
      if (rst) begin
         model_reset();
      end else begin
         if (c[6]) m_stall_cnt = (m_stall_cnt + 1) % CNT_MOD;
         if (c[2]) m_flush_cnt = (m_flush_cnt + 1) % CNT_MOD;
         if (MemBusy) m_busy_run = (m_busy_run < 1000) ? m_busy_run + 1 : m_busy_run;
         else         m_busy_run = 0;
         if (m_busy_run >= WD_LIMIT) m_timeout = 1'b1;
      end
   endtask

   task automatic check_all();
      chk("ctrl",       64'(obs_ctrl),   64'(exp_ctrl()));
      chk("fwd_a",      64'(ForwardAE),  64'(exp_fwd(Rs1E)));
      chk("fwd_b",      64'(ForwardBE),  64'(exp_fwd(Rs2E)));
      chk("stall_cnt",  64'(StallCount), 64'(m_stall_cnt));
      chk("flush_cnt",  64'(FlushCount), 64'(m_flush_cnt));
      chk("timeout",    64'(MemTimeout), 64'(m_timeout));
   endtask

   // Check at the falling edge, then advance the model across the rising edge.
   task automatic run_cycle();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
      RdE = '0; RdM = '0; RdW = '0;
      LoadE = 1'b0; RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      PCSrcE = 1'b0; MemBusy = 1'b0;
   endtask

   int burst;

   initial begin
      clear_inputs();
      rst = 1'b1;
      model_reset();
      #2;
      chk("rst_ctrl",  64'(obs_ctrl),   64'(C_IDLE));
      chk("rst_scnt",  64'(StallCount), 64'd0);
      check_all();
      @(posedge clk);
      model_update();
      #1;
      rst = 1'b0;
      run_cycle();

      // load-use on Rs1D: one bubble
      Rs1D = 5; RdE = 5; LoadE = 1'b1; RegWriteE = 1'b1;
      #1 chk("lu_ctrl", 64'(obs_ctrl), 64'(C_HAZ));
      run_cycle();
      chk("lu_scnt", 64'(StallCount), 64'd1);
      clear_inputs();
      #1 chk("lu_clean", 64'(obs_ctrl), 64'(C_IDLE));
      run_cycle();

      // taken branch overrides load-use
      Rs1D = 5; RdE = 5; LoadE = 1'b1; RegWriteE = 1'b1; PCSrcE = 1'b1;
      #1 chk("br_ctrl", 64'(obs_ctrl), 64'(C_BR));
      run_cycle();
      chk("br_fcnt", 64'(FlushCount), 64'd1);
      chk("br_scnt", 64'(StallCount), 64'd1);
      clear_inputs();

      // M beats W; x0 never forwards
      RegWriteM = 1'b1; RdM = 7; RegWriteW = 1'b1; RdW = 7; Rs1E = 7; Rs2E = 0;
      #1;
      chk("fwd_mw_a", 64'(ForwardAE), 64'(FWD_EN ? 2'b10 : 2'b00));
      chk("fwd_mw_b", 64'(ForwardBE), 64'(2'b00));
      run_cycle();
      RegWriteM = 1'b0;
      #1 chk("fwd_w_a", 64'(ForwardAE), 64'(FWD_EN ? 2'b01 : 2'b00));
      run_cycle();
      clear_inputs();

      // short memory wait
      MemBusy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("busy_ctrl", 64'(obs_ctrl), 64'(C_BUSY));
         run_cycle();
      end
      MemBusy = 1'b0;
      #1 chk("busy_end", 64'(obs_ctrl), 64'(C_IDLE));
      run_cycle();
      chk("busy_to", 64'(MemTimeout), 64'd0);

      // long memory wait trips the watchdog after the 15th wait cycle
      MemBusy = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         run_cycle();
         chk("wd_to", 64'(MemTimeout), 64'(i >= WD_LIMIT));
      end
      MemBusy = 1'b0;
      repeat (3) run_cycle();
      chk("wd_hold", 64'(MemTimeout), 64'd1);

      // asynchronous reset in the middle of a wait
      MemBusy = 1'b1; RegWriteM = 1'b1; RdM = 7; Rs1E = 7;
      repeat (2) run_cycle();
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("ar_ctrl", 64'(obs_ctrl),   64'(C_IDLE));
      chk("ar_fwd",  64'(ForwardAE),  64'd0);
      chk("ar_scnt", 64'(StallCount), 64'd0);
      chk("ar_fcnt", 64'(FlushCount), 64'd0);
      chk("ar_to",   64'(MemTimeout), 64'd0);
      MemBusy = 1'b0;
      run_cycle();
      rst = 1'b0;
      clear_inputs();
      run_cycle();
      MemBusy = 1'b1;
      repeat (2) run_cycle();
      MemBusy = 1'b0;
      run_cycle();

      // pending M write against Rs2D
      RegWriteM = 1'b1; RdM = 3; Rs2D = 3;
      #1;
      chk("m_dep_stalld", 64'(StallD),    64'(!FWD_EN));
      chk("m_dep_fwdb",   64'(ForwardBE), 64'd0);
      run_cycle();
      clear_inputs();
      #1 chk("m_dep_clean", 64'(StallD), 64'd0);
      run_cycle();

      // randomized traffic
      burst = 0;
      for (int n = 0; n < 600; n++) begin
         Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
         Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
         RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
         RdW  = AW'($urandom_range(0, 3));
         LoadE = 1'($urandom); RegWriteE = 1'($urandom);
         RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         PCSrcE = ($urandom_range(0, 5) == 0);
         if (burst == 0 && $urandom_range(0, 60) == 0) burst = $urandom_range(12, 18);
         if (burst > 0) begin
            MemBusy = 1'b1;
            burst--;
         end else begin
            MemBusy = ($urandom_range(0, 4) == 0);
         end
         rst = ($urandom_range(0, 99) == 0);
         if (rst) model_reset();
         run_cycle();
      end
      rst = 1'b0;
      clear_inputs();
      run_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_ADDR_WIDTH, default 5, register-index width.
REQ-002 The block SHALL have parameter TIMEOUT_W, default 8, memory-wait watchdog counter width.
REQ-003 The block SHALL have parameter CNT_W, default 32, performance counter width.
REQ-004 The block SHALL have port clk, input, 1, single clock; one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have ports Rs1D and Rs2D, input, REG_ADDR_WIDTH each, source registers in Decode.
REQ-007 The block SHALL have ports Rs1E, Rs2E and RdE, input, REG_ADDR_WIDTH each, sources and destination in Execute.
REQ-008 The block SHALL have ports LoadE and RegWriteE, input, 1 each: Execute holds a load; Execute writes a register.
REQ-009 The block SHALL have ports RdM, input, REG_ADDR_WIDTH, and RegWriteM, input, 1, Memory-stage destination and write enable.
REQ-010 The block SHALL have ports RdW, input, REG_ADDR_WIDTH, and RegWriteW, input, 1, Writeback-stage destination and write enable.
REQ-011 The block SHALL have port PCSrcE, input, 1, taken branch or jump resolved in Execute.
REQ-012 The block SHALL have port MemBusy, input, 1, data memory not ready.
REQ-013 The block SHALL have ports StallF, StallD, StallE and StallM, output, 1 each, hold the PC and the F/D, D/E and E/M registers.
REQ-014 The block SHALL have ports FlushD, FlushE and FlushW, output, 1 each, bubble into the F/D, D/E and M/W registers.
REQ-015 The block SHALL have ports ForwardAE and ForwardBE, output, 2 each: 00 = register file, 10 = M-stage result, 01 = W-stage result.
REQ-016 The block SHALL have port MemTimeout, output, 1, sticky watchdog flag.
REQ-017 The block SHALL have ports StallCount and FlushCount, output, CNT_W each, performance counters.

Function
REQ-018 The FSM SHALL have states RUN and MEM_WAIT.
REQ-019 The FSM SHALL move from RUN to MEM_WAIT on a clock edge where MemBusy=1.
REQ-020 The FSM SHALL move from MEM_WAIT to RUN on the first edge where MemBusy=0.
REQ-021 Stall and flush outputs SHALL be combinational from state and current inputs (Mealy).
REQ-022 Whenever MemBusy=1, in either state, StallF, StallD, StallE, StallM and FlushW SHALL be 1 and all other stall/flush outputs 0; this has highest priority.
REQ-023 When MemBusy=0 and PCSrcE=1, FlushD and FlushE SHALL be 1 and all stalls 0; flush overrides a simultaneous load-use stall.
REQ-024 Load-use SHALL be defined as LoadE=1 and RdE!=0 and RdE equal to Rs1D or Rs2D.
REQ-025 On load-use with MemBusy=0 and PCSrcE=0, StallF, StallD and FlushE SHALL be 1 for exactly that cycle, giving a one-bubble penalty.
REQ-026 Forward select for A SHALL be 10 if RegWriteM=1, RdM!=0 and RdM=Rs1E.
REQ-027 Otherwise forward select for A SHALL be 01 if RegWriteW=1, RdW!=0 and RdW=Rs1E, else 00; M beats W.
REQ-028 Forward select for B SHALL follow the same rules as A using Rs2E.
REQ-029 Register x0 SHALL never trigger a stall or a forward.
REQ-030 The register file is write-first, so a W-stage to D-stage hazard SHALL cause no stall.
REQ-031 The watchdog counter SHALL increment each MEM_WAIT cycle and clear on entry to RUN.
REQ-032 MemTimeout SHALL set when the watchdog counter reaches 2^TIMEOUT_W-1 and stay set until reset.
REQ-033 The watchdog counter SHALL saturate and not wrap.
REQ-034 StallCount SHALL increment on any cycle with StallF=1.
REQ-035 FlushCount SHALL increment on any cycle with FlushD=1.
REQ-036 Both performance counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-037 rst=1 SHALL force state RUN, watchdog counter 0, MemTimeout=0, StallCount=0 and FlushCount=0 immediately, without waiting for a clock edge.
REQ-038 While rst=1, all stall and flush outputs SHALL be 0 and ForwardAE=ForwardBE=00.
REQ-039 Reset asserted during MEM_WAIT SHALL abandon the wait; after release the FSM SHALL re-enter MEM_WAIT only on a fresh edge with MemBusy=1.

Configuration
REQ-040 With macro HAZARD_FORWARD_EN defined, the forwarding of REQ-026 to REQ-028 and the single-bubble load-use of REQ-025 SHALL apply.
REQ-041 Without HAZARD_FORWARD_EN, ForwardAE and ForwardBE SHALL be tied to 00.
REQ-042 Without HAZARD_FORWARD_EN, a stall (StallF, StallD, FlushE) SHALL replace REQ-024 and REQ-025 whenever Rs1D or Rs2D, if nonzero, matches RdE with RegWriteE=1 or RdM with RegWriteM=1.
REQ-043 Without HAZARD_FORWARD_EN, the priority of REQ-022 and REQ-023 SHALL be unchanged.

Verification
REQ-044 The bench SHALL cover: LoadE=1, RdE=5, Rs1D=5 -> one cycle with StallF=StallD=FlushE=1, StallCount=1; the next cycle is clean.
REQ-045 The bench SHALL cover: PCSrcE=1 in the same cycle as a load-use match -> FlushD=FlushE=1, StallF=0, FlushCount=1.
REQ-046 The bench SHALL cover: RegWriteM=1, RdM=7 and RegWriteW=1, RdW=7, Rs1E=7, Rs2E=0 -> ForwardAE=10, ForwardBE=00.
REQ-047 The bench SHALL cover: MemBusy high for 3 cycles -> state MEM_WAIT for 3 cycles with StallF..StallM=1 and FlushW=1, then RUN, MemTimeout=0.
REQ-048 The bench SHALL cover: TIMEOUT_W=4 with MemBusy high for 20 cycles -> MemTimeout=1 after the 15th wait cycle and held after MemBusy falls.
REQ-049 The bench SHALL cover: rst pulsed mid-MEM_WAIT -> outputs drop to 0 and counters read 0 without a clock edge.
REQ-050 The bench SHALL cover: build without HAZARD_FORWARD_EN, RegWriteM=1, RdM=3, Rs2D=3 -> StallD=1 for one cycle and ForwardBE=00.
